// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle for the shared ALU arbiter: per-requester request handshake
// plus the broadcast response.
interface alu_share_arbiter_if #(
   parameter int N_REQ = 2,
   parameter int WIDTH = 32
);
   logic [N_REQ-1:0]       req_valid;
   logic [5*N_REQ-1:0]     req_op;
   logic [WIDTH*N_REQ-1:0] req_a;
   logic [WIDTH*N_REQ-1:0] req_b;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]       rsp_data;
   logic                   rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between N_REQ requesters; one transaction
// takes IDLE -> EXEC -> RESP, one cycle each.
//
// state  | meaning
// IDLE   | waiting for a request; grants and latches operands combinationally
// EXEC   | latched operands driven to the ALU, result captured at the edge
// RESP   | one-cycle rsp_valid pulse to the granted requester
module alu_share_arbiter #(
   parameter int N_REQ = 2,
   parameter int WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   alu_share_arbiter_if.slave  bus,
   output logic [4:0]          alu_op,
   output logic [WIDTH-1:0]    alu_a,
   output logic [WIDTH-1:0]    alu_b,
   input  logic [WIDTH-1:0]    alu_out,
   output logic                busy
);
   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [4:0] OP_ADD = 5'b00001;
   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_AND = 5'b00100;
   localparam logic [4:0] OP_SLT = 5'b01000;
   localparam logic [4:0] OP_OR  = 5'b10000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [GW-1:0]     last_q, last_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic [4:0]        op_q, op_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              err_q, err_d;
   logic [GW-1:0]     pick;
   logic              found;
   logic              op_legal;

   // Search starts one past the last grant so every requester gets a turn.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!found && bus.req_valid[(int'(last_q) + k) % N_REQ]) begin
            found = 1'b1;
            pick  = GW'((int'(last_q) + k) % N_REQ);
         end
      end
   end

   always_comb begin
      case (op_q)
         OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_OR: op_legal = 1'b1;
         default:                               op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      grant_d       = grant_q;
      op_d          = op_q;
      a_d           = a_q;
      b_d           = b_q;
      result_d      = result_q;
      err_d         = err_q;
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      alu_op        = '0;
      alu_a         = '0;
      alu_b         = '0;
      case (state_q)
         S_IDLE: begin
            if (found && !rst) begin
               bus.req_ready[pick] = 1'b1;
               grant_d = pick;
               last_d  = pick;
               op_d    = bus.req_op[5*int'(pick) +: 5];
               a_d     = bus.req_a[WIDTH*int'(pick) +: WIDTH];
               b_d     = bus.req_b[WIDTH*int'(pick) +: WIDTH];
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_a = a_q;
            alu_b = b_q;
            if (op_legal) begin
               alu_op   = op_q;
               result_d = alu_out;
               err_d    = 1'b0;
            end else begin
               result_d = '0;
               err_d    = 1'b1;
            end
            state_d = S_RESP;
         end
         S_RESP: begin
            bus.rsp_valid[grant_q] = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         last_q   <= GW'(N_REQ - 1);
         grant_q  <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign bus.rsp_data = result_q;
   assign bus.rsp_err  = (state_q == S_RESP) && err_q;
   assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with two requesters and a behavioural ALU.
module tb_alu_share_arbiter;
   localparam int N_REQ = 2;
   localparam int WIDTH = 32;

   localparam logic [4:0] OP_ADD = 5'b00001;
   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_AND = 5'b00100;
   localparam logic [4:0] OP_SLT = 5'b01000;
   localparam logic [4:0] OP_OR  = 5'b10000;

   logic             clk;
   logic             rst;
   logic [4:0]       alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_out;
   logic             busy;

   int vectors;
   int miscompares;

   alu_share_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

   alu_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .alu_op  (alu_op),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_out (alu_out),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; unknown opcodes return a marker so a leaked value is visible.
   always_comb begin
      case (alu_op)
         OP_ADD:  alu_out = alu_a + alu_b;
         OP_SUB:  alu_out = alu_a - alu_b;
         OP_AND:  alu_out = alu_a & alu_b;
         OP_SLT:  alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
         OP_OR:   alu_out = alu_a | alu_b;
         default: alu_out = 32'hDEAD_BEEF;
      endcase
   end

   task automatic do_req(input int idx, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] data, output logic err,
                         output logic [4:0] exec_op, output logic [1:0] rv,
                         output int wait_cycles, output bit ok);
      ok = 1'b0;
      wait_cycles = 0;
      data = '0; err = 1'b0; exec_op = '0; rv = '0;
      @(negedge clk);
      bus.req_op[5*idx +: 5]   = op;
      bus.req_a[32*idx +: 32]  = a;
      bus.req_b[32*idx +: 32]  = b;
      bus.req_valid[idx]       = 1'b1;
      for (int c = 0; c < 10 && !ok; c++) begin
         #1;
         if (bus.req_ready[idx]) ok = 1'b1;
         else begin
            wait_cycles++;
            @(negedge clk);
         end
      end
      if (ok) begin
         @(posedge clk);
         @(negedge clk);
         bus.req_valid[idx] = 1'b0;
         exec_op = alu_op;
         @(negedge clk);
         data = bus.rsp_data;
         err  = bus.rsp_err;
         rv   = bus.rsp_valid;
      end else begin
         bus.req_valid[idx] = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_ctl: busy=%b req_ready=%b rsp_valid=%b, required 0/00/00",
                  busy, bus.req_ready, bus.rsp_valid);
      end
      vectors++;
      if (bus.rsp_data !== 32'd0 || bus.rsp_err !== 1'b0 || alu_op !== 5'd0 ||
          alu_a !== 32'd0 || alu_b !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_data: rsp_data=%h rsp_err=%b alu_op=%b alu_a=%h alu_b=%h, required all 0",
                  bus.rsp_data, bus.rsp_err, alu_op, alu_a, alu_b);
      end
      bus.req_valid = '0;
      rst = 1'b0;
   endtask

   task automatic test_add();
      logic [31:0] d; logic e; logic [4:0] xo; logic [1:0] rv; int w; bit ok;
      do_req(0, OP_ADD, 32'd5, 32'd7, d, e, xo, rv, w, ok);
      vectors++;
      if (!ok || w !== 0) begin
         miscompares++;
         $display("FAIL add_ready: granted=%0d wait=%0d, required granted=1 wait=0", ok, w);
      end
      vectors++;
      if (xo !== OP_ADD) begin
         miscompares++;
         $display("FAIL add_exec_op: alu_op=%b, required %b", xo, OP_ADD);
      end
      vectors++;
      if (rv !== 2'b01 || d !== 32'd12 || e !== 1'b0) begin
         miscompares++;
         $display("FAIL add_rsp: rsp_valid=%b data=%0d err=%b, required 01/12/0", rv, d, e);
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_data [2];
      int g;
      exp_data[0] = 32'd7;
      exp_data[1] = 32'h0000_00FF;
      pulse_reset();
      bus.req_op  = {OP_OR, OP_SUB};
      bus.req_a   = {32'h0000_00F0, 32'd10};
      bus.req_b   = {32'h0000_000F, 32'd3};
      bus.req_valid = 2'b11;
      for (int c = 0; c < 12; c++) begin
         #1;
         g = (c / 3) % 2;
         vectors++;
         if (bus.rsp_valid === 2'b11) begin
            miscompares++;
            $display("FAIL rr_onehot: cycle %0d rsp_valid=%b, required at most one bit", c, bus.rsp_valid);
         end
         if (c % 3 == 0) begin
            vectors++;
            if (bus.req_ready !== 2'(1 << g)) begin
               miscompares++;
               $display("FAIL rr_grant: cycle %0d req_ready=%b, required %b", c, bus.req_ready, 2'(1 << g));
            end
         end else if (c % 3 == 2) begin
            vectors++;
            if (bus.rsp_valid !== 2'(1 << g) || bus.rsp_data !== exp_data[g]) begin
               miscompares++;
               $display("FAIL rr_rsp: cycle %0d rsp_valid=%b data=%h, required %b/%h",
                        c, bus.rsp_valid, bus.rsp_data, 2'(1 << g), exp_data[g]);
            end
         end else begin
            vectors++;
            if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) begin
               miscompares++;
               $display("FAIL rr_exec: cycle %0d req_ready=%b rsp_valid=%b, required 00/00",
                        c, bus.req_ready, bus.rsp_valid);
            end
         end
         @(negedge clk);
      end
      bus.req_valid = 2'b00;
   endtask

   task automatic test_slt();
      logic [31:0] d; logic e; logic [4:0] xo; logic [1:0] rv; int w; bit ok;
      do_req(0, OP_SLT, 32'hFFFF_FFFF, 32'd1, d, e, xo, rv, w, ok);
      vectors++;
      if (!ok || rv !== 2'b01 || d !== 32'd0) begin
         miscompares++;
         $display("FAIL slt_big: granted=%0d rsp_valid=%b data=%h, required 1/01/0", ok, rv, d);
      end
      do_req(0, OP_SLT, 32'd1, 32'd2, d, e, xo, rv, w, ok);
      vectors++;
      if (!ok || rv !== 2'b01 || d !== 32'd1) begin
         miscompares++;
         $display("FAIL slt_small: granted=%0d rsp_valid=%b data=%h, required 1/01/1", ok, rv, d);
      end
   endtask

   task automatic test_illegal_op();
      logic [31:0] d; logic e; logic [4:0] xo; logic [1:0] rv; int w; bit ok;
      do_req(0, 5'b00011, 32'd4, 32'd4, d, e, xo, rv, w, ok);
      vectors++;
      if (!ok || xo !== 5'b00000) begin
         miscompares++;
         $display("FAIL illegal_exec_op: granted=%0d alu_op=%b, required 1/00000", ok, xo);
      end
      vectors++;
      if (rv !== 2'b01 || d !== 32'd0 || e !== 1'b1) begin
         miscompares++;
         $display("FAIL illegal_rsp: rsp_valid=%b data=%h err=%b, required 01/0/1", rv, d, e);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] d; logic e; logic [4:0] xo; logic [1:0] rv; int w; bit ok;
      @(negedge clk);
      bus.req_op[4:0]  = OP_ADD;
      bus.req_a[31:0]  = 32'd1;
      bus.req_b[31:0]  = 32'd1;
      bus.req_valid[0] = 1'b1;
      #1;
      vectors++;
      if (bus.req_ready !== 2'b01) begin
         miscompares++;
         $display("FAIL midrst_accept: req_ready=%b, required 01", bus.req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid[0] = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_exec_busy: busy=%b, required 1", busy);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL midrst_after: busy=%b rsp_valid=%b, required 0/00", busy, bus.rsp_valid);
      end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_dropped: cycle %0d rsp_valid=%b busy=%b, required 00/0",
                     c, bus.rsp_valid, busy);
         end
      end
      do_req(0, OP_ADD, 32'd2, 32'd3, d, e, xo, rv, w, ok);
      vectors++;
      if (!ok || w !== 0 || rv !== 2'b01 || d !== 32'd5) begin
         miscompares++;
         $display("FAIL midrst_next: granted=%0d wait=%0d rsp_valid=%b data=%0d, required 1/0/01/5",
                  ok, w, rv, d);
      end
   endtask

   task automatic test_wait_while_busy();
      @(negedge clk);
      bus.req_op[4:0]  = OP_SUB;
      bus.req_a[31:0]  = 32'd9;
      bus.req_b[31:0]  = 32'd4;
      bus.req_valid    = 2'b01;
      #1;
      vectors++;
      if (bus.req_ready !== 2'b01) begin
         miscompares++;
         $display("FAIL busy_accept0: req_ready=%b, required 01", bus.req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_op[9:5]   = OP_AND;
      bus.req_a[63:32]  = 32'h0000_F0F0;
      bus.req_b[63:32]  = 32'h0000_FF00;
      bus.req_valid     = 2'b10;
      #1;
      vectors++;
      if (bus.req_ready !== 2'b00) begin
         miscompares++;
         $display("FAIL busy_exec_ready: req_ready=%b, required 00", bus.req_ready);
      end
      @(negedge clk);
      #1;
      vectors++;
      if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'd5) begin
         miscompares++;
         $display("FAIL busy_resp: req_ready=%b rsp_valid=%b data=%0d, required 00/01/5",
                  bus.req_ready, bus.rsp_valid, bus.rsp_data);
      end
      @(negedge clk);
      #1;
      vectors++;
      if (bus.req_ready !== 2'b10) begin
         miscompares++;
         $display("FAIL busy_accept1: req_ready=%b, required 10", bus.req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 2'b00;
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'h0000_F000 || bus.rsp_err !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_rsp1: rsp_valid=%b data=%h err=%b, required 10/0000f000/0",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_err);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      test_reset();
      test_add();
      test_round_robin();
      test_slt();
      test_illegal_op();
      test_reset_mid_op();
      test_wait_while_busy();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
